// File: rtl/uci_pkg.sv
// Shared types and constants for the UCI output path: byte type, line
// framing characters, serializer states and well-known channel slots.
package uci_pkg;

   typedef logic [7:0] char_t;

   localparam char_t NEW_LINE = 8'h0A;
   localparam char_t NUL      = 8'h00;

   typedef enum logic [1:0] {
      SER_IDLE,
      SER_SEND,
      SER_NEWLINE
   } ser_state_t;

   localparam int CH_BESTMOVE = 0;
   localparam int CH_ID       = 1;
   localparam int CH_READYOK  = 2;
   localparam int CH_INFO     = 3;

endpackage

// File: rtl/uci_rr_arbiter.sv
// Combinational one-hot arbiter: fixed priority (lowest index wins) or
// round-robin starting at the slot after the previous grant.
module uci_rr_arbiter #(
   parameter int N  = 4,
   parameter bit RR = 1'b0,
   localparam int LW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [LW-1:0] last_grant,
   input  logic          en,
   output logic [N-1:0]  grant
);

   logic found;

   // Search position i maps to a request slot; round-robin rotates the
   // search so it starts right after the last grant and wraps.
   function automatic logic [LW-1:0] slot(input int i, input logic [LW-1:0] lg);
      if (RR)
         return LW'((32'(lg) + 32'(i) + 1) % N);
      else
         return LW'(i);
   endfunction

   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (en && !found && req[slot(i, last_grant)]) begin
            grant[slot(i, last_grant)] = 1'b1;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uci_line_serializer.sv
// Multi-channel UCI line serializer: accepts whole NUL-terminated messages,
// emits them byte by byte followed by a newline, never interleaving lines.
module uci_line_serializer
   import uci_pkg::*;
#(
   parameter int                NUM_CH     = 4,
   parameter int                MSG_LEN    = 64,
   parameter bit                ARB_RR     = 1'b0,
   parameter logic [NUM_CH-1:0] DEBUG_MASK = '0
) (
   input  logic                              clk_in,
   input  logic                              rst_in,
   input  logic [NUM_CH-1:0][MSG_LEN-1:0][7:0] msg_in,
   input  logic [NUM_CH-1:0]                 msg_in_valid,
   output logic [NUM_CH-1:0]                 msg_in_ready,
   input  logic                              in_debug,
   output char_t                             char_out,
   output logic                              char_out_valid,
   input  logic                              char_out_ready,
   output logic                              busy_out
);

   localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef logic [MSG_LEN-1:0][7:0] msg_t;

   ser_state_t        state, state_next;
   msg_t              msg_buf, buf_next;
   logic [IDX_W-1:0]  idx, idx_next;
   char_t             char_next;
   logic              valid_next;
   logic [CH_W-1:0]   last_grant, last_grant_next, grant_idx;
   logic [NUM_CH-1:0] grant;
   logic              accept, drop, byte_hs, arb_en;
   char_t             next_char;
   msg_t              sel_msg;

   // Grants are only offered from IDLE and never while reset is held.
   assign arb_en = rst_in && (state == SER_IDLE);

   uci_rr_arbiter #(
      .N  (NUM_CH),
      .RR (ARB_RR)
   ) u_arb (
      .req        (msg_in_valid),
      .last_grant (last_grant),
      .en         (arb_en),
      .grant      (grant)
   );

   assign msg_in_ready = grant;
   assign accept       = |(msg_in_valid & grant);
   assign byte_hs      = char_out_valid && char_out_ready;
   assign busy_out     = (state == SER_SEND) || (state == SER_NEWLINE);

   always_comb begin
      grant_idx = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (grant[c])
            grant_idx = CH_W'(c);
      end
   end

   assign sel_msg = msg_in[grant_idx];
   assign drop    = DEBUG_MASK[grant_idx] && !in_debug;

   // A full-length buffer behaves as if a NUL followed its last byte.
   assign next_char = (idx == IDX_W'(MSG_LEN - 1)) ? NUL : msg_buf[idx + 1'b1];

   always_comb begin
      state_next      = state;
      buf_next        = msg_buf;
      idx_next        = idx;
      char_next       = char_out;
      valid_next      = char_out_valid;
      last_grant_next = last_grant;
      case (state)
         SER_IDLE: begin
            if (accept) begin
               buf_next        = sel_msg;
               idx_next        = '0;
               last_grant_next = grant_idx;
               if (!drop) begin
                  valid_next = 1'b1;
                  if (sel_msg[0] == NUL) begin
                     state_next = SER_NEWLINE;
                     char_next  = NEW_LINE;
                  end else begin
                     state_next = SER_SEND;
                     char_next  = sel_msg[0];
                  end
               end
            end
         end
         SER_SEND: begin
            if (byte_hs) begin
               if (next_char == NUL) begin
                  state_next = SER_NEWLINE;
                  char_next  = NEW_LINE;
               end else begin
                  idx_next  = idx + 1'b1;
                  char_next = next_char;
               end
            end
         end
         SER_NEWLINE: begin
            if (byte_hs) begin
               state_next = SER_IDLE;
               valid_next = 1'b0;
               char_next  = NUL;
            end
         end
         default: begin
            state_next = SER_IDLE;
            valid_next = 1'b0;
            char_next  = NUL;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state          <= SER_IDLE;
         msg_buf        <= '0;
         idx            <= '0;
         char_out       <= NUL;
         char_out_valid <= 1'b0;
         last_grant     <= CH_W'(NUM_CH - 1);
      end else begin
         state          <= state_next;
         msg_buf        <= buf_next;
         idx            <= idx_next;
         char_out       <= char_next;
         char_out_valid <= valid_next;
         last_grant     <= last_grant_next;
      end
   end

endmodule
